exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: stop  in  1  global stall, held high freezes all state.
REQ-004 SHALL have: flush  in  1  synchronous kill of all in-flight ops.
REQ-005 SHALL have: issue_valid  in  2  per-lane issue strobe from reservation station.
REQ-006 SHALL have per lane k=0..1: issue_rd[k] in 8, issue_rs1_val[k] in 32, issue_rs2_val[k] in 32, issue_op[k] in 4, issue_rob_tag[k] in 7.
REQ-007 SHALL have: cdb_valid  out  4  result broadcast strobes.
REQ-008 SHALL have per CDB lane c=0..3: cdb_tag[c] out 8 (destination phys reg), cdb_data[c] out 32, cdb_rob_tag[c] out 7.
REQ-009 SHALL have: busy  out  1  high while any op is in flight.

Function
REQ-010 SHALL accept every issue lane with issue_valid=1 at a clock edge where stop=0 and flush=0; no backpressure.
REQ-011 SHALL decode op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL; 11-15 reserved.
REQ-012 Shifts SHALL use rs2_val[4:0] only; MUL SHALL return low 32 bits of the unsigned product; ADD/SUB SHALL wrap modulo 2^32.
REQ-013 Reserved ops SHALL complete on the ALU path with data 32'h0.
REQ-014 Non-MUL op on issue lane k SHALL appear on CDB lane k exactly 1 accepted cycle after issue.
REQ-015 MUL on issue lane k SHALL pass a 3-stage pipeline and appear on CDB lane k+2 exactly 3 accepted cycles after issue.
REQ-016 CDB lane assignment is fixed, so up to 4 results per cycle SHALL broadcast without arbitration or loss.
REQ-017 cdb_tag SHALL equal issued rd; cdb_rob_tag SHALL equal issued rob_tag.
REQ-018 An ALU or MUL stage holding no valid op SHALL drive cdb_valid low for its lane; data/tag values are don't-care.
REQ-019 While stop=1: pipeline registers, valid bits and busy SHALL hold; cdb_valid SHALL be forced 0; issue inputs SHALL be ignored.
REQ-020 On stop deassertion, frozen results SHALL broadcast on the first cycle with stop=0, each exactly once.
REQ-021 flush=1 at an edge SHALL clear every stage valid bit; issue in that cycle SHALL be discarded; flush SHALL take priority over stop.
REQ-022 busy SHALL be the combinational OR of all stage valid bits (ALU output regs, 3 MUL stages, both lanes).
REQ-023 Ops issued on both lanes in one cycle with identical rd SHALL both broadcast; ordering is the responsibility of the renamer.

Reset
REQ-024 reset low SHALL asynchronously clear all valid bits; cdb_valid=4'b0000, busy=0, cdb_tag/cdb_data/cdb_rob_tag=0.
REQ-025 Reset asserted mid-MUL SHALL discard the op; no broadcast SHALL follow reset release.
REQ-026 First accepted issue SHALL be the first edge after reset release with stop=0.

Verification
REQ-027 Lane0 ADD rs1=32'h7FFFFFFF rs2=1 rd=8'h12 rob=7'h05 -> next cycle cdb_valid[0]=1, cdb_data[0]=32'h80000000, cdb_tag[0]=8'h12, cdb_rob_tag[0]=7'h05.
REQ-028 Lane1 MUL 32'h00010000 x 32'h00010001 rd=8'h20 -> cycles 1-2 cdb_valid[3]=0, cycle 3 cdb_valid[3]=1, data 32'h00010000.
REQ-029 Same cycle: lane0 MUL, lane1 SRA 32'h80000000 by 4; 2 cycles later both lanes ADD -> cycle 1 cdb[1]=32'hF8000000; cycle 3 cdb_valid=4'b0111.
REQ-030 MUL issued, stop high 5 cycles after 1st stage -> cdb_valid=0 during stop, busy=1; broadcast once exactly 2 unstalled cycles after stop falls.
REQ-031 Two MULs in flight, flush pulse -> no broadcast afterwards, busy=0 next cycle; same-cycle issue discarded.
REQ-032 Reset low during MUL stage 2 -> cdb_valid=0, busy=0 immediately; no broadcast after release.

Source files
------------

// File: rtl/exec_unit.sv
// exec_unit: two-lane integer execution unit feeding a four-lane result bus.
//   Lane k non-MUL ops take one cycle and broadcast on CDB lane k.
//   Lane k MUL ops pass a three-stage pipeline and broadcast on CDB lane k+2.
//   Fixed lane mapping means up to four results per cycle with no arbitration.
// Ports:
//   clk, reset (async active-low), stop (global stall), flush (kill in-flight ops)
//   issue_valid[1:0] plus per-lane issue_rd/rs1_val/rs2_val/op/rob_tag
//   cdb_valid[3:0] plus per-lane cdb_tag/cdb_data/cdb_rob_tag
//   busy: any stage holds a valid op
module exec_unit (
    input  logic             clk,
    input  logic             reset,
    input  logic             stop,
    input  logic             flush,
    input  logic [1:0]       issue_valid,
    input  logic [1:0][7:0]  issue_rd,
    input  logic [1:0][31:0] issue_rs1_val,
    input  logic [1:0][31:0] issue_rs2_val,
    input  logic [1:0][3:0]  issue_op,
    input  logic [1:0][6:0]  issue_rob_tag,
    output logic [3:0]       cdb_valid,
    output logic [3:0][7:0]  cdb_tag,
    output logic [3:0][31:0] cdb_data,
    output logic [3:0][6:0]  cdb_rob_tag,
    output logic             busy
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    // Per-lane state: ALU output register and three MUL stages.
    // Stage 1 holds operands, stage 2 the product, stage 3 the broadcast copy.
    typedef struct packed {
        logic        alu_vld;
        logic [31:0] alu_data;
        logic [7:0]  alu_rd;
        logic [6:0]  alu_rob;
        logic        m1_vld;
        logic [31:0] m1_a;
        logic [31:0] m1_b;
        logic [7:0]  m1_rd;
        logic [6:0]  m1_rob;
        logic        m2_vld;
        logic [31:0] m2_p;
        logic [7:0]  m2_rd;
        logic [6:0]  m2_rob;
        logic        m3_vld;
        logic [31:0] m3_p;
        logic [7:0]  m3_rd;
        logic [6:0]  m3_rob;
    } lane_t;

    lane_t [1:0] ln_q;
    lane_t [1:0] ln_d;

    // Single-cycle ALU; MUL never reaches here and reserved codes yield zero.
    function automatic logic [31:0] alu_calc(input logic [3:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << b[4:0];
            OP_SRL:  r = a >> b[4:0];
            OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            OP_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
            OP_SLTU: r = {31'd0, (a < b)};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Next-state: flush clears valids (even under stop), stop freezes, else advance.
    always_comb begin
        ln_d = ln_q;
        if (flush) begin
            for (int k = 0; k < 2; k++) begin
                ln_d[k].alu_vld = 1'b0;
                ln_d[k].m1_vld  = 1'b0;
                ln_d[k].m2_vld  = 1'b0;
                ln_d[k].m3_vld  = 1'b0;
            end
        end else if (!stop) begin
            for (int k = 0; k < 2; k++) begin
                ln_d[k].alu_vld  = issue_valid[k] && (issue_op[k] != OP_MUL);
                ln_d[k].alu_data = alu_calc(issue_op[k], issue_rs1_val[k], issue_rs2_val[k]);
                ln_d[k].alu_rd   = issue_rd[k];
                ln_d[k].alu_rob  = issue_rob_tag[k];
                ln_d[k].m1_vld   = issue_valid[k] && (issue_op[k] == OP_MUL);
                ln_d[k].m1_a     = issue_rs1_val[k];
                ln_d[k].m1_b     = issue_rs2_val[k];
                ln_d[k].m1_rd    = issue_rd[k];
                ln_d[k].m1_rob   = issue_rob_tag[k];
                ln_d[k].m2_vld   = ln_q[k].m1_vld;
                ln_d[k].m2_p     = ln_q[k].m1_a * ln_q[k].m1_b;
                ln_d[k].m2_rd    = ln_q[k].m1_rd;
                ln_d[k].m2_rob   = ln_q[k].m1_rob;
                ln_d[k].m3_vld   = ln_q[k].m2_vld;
                ln_d[k].m3_p     = ln_q[k].m2_p;
                ln_d[k].m3_rd    = ln_q[k].m2_rd;
                ln_d[k].m3_rob   = ln_q[k].m2_rob;
            end
        end else begin
            ln_d = ln_q;
        end
    end

    // Pipeline state register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ln_q <= '0;
        end else begin
            ln_q <= ln_d;
        end
    end

    // CDB drive: valids gated by stop so a frozen result broadcasts only once it moves on.
    always_comb begin
        cdb_valid   = 4'b0000;
        cdb_tag     = '0;
        cdb_data    = '0;
        cdb_rob_tag = '0;
        busy        = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cdb_valid[k]     = ln_q[k].alu_vld & ~stop;
            cdb_tag[k]       = ln_q[k].alu_rd;
            cdb_data[k]      = ln_q[k].alu_data;
            cdb_rob_tag[k]   = ln_q[k].alu_rob;
            cdb_valid[k+2]   = ln_q[k].m3_vld & ~stop;
            cdb_tag[k+2]     = ln_q[k].m3_rd;
            cdb_data[k+2]    = ln_q[k].m3_p;
            cdb_rob_tag[k+2] = ln_q[k].m3_rob;
            busy = busy | ln_q[k].alu_vld | ln_q[k].m1_vld | ln_q[k].m2_vld | ln_q[k].m3_vld;
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed testbench for exec_unit: linear stimulus, hand-computed expectations.
module tb_exec_unit;

    logic             clk;
    logic             reset;
    logic             stop;
    logic             flush;
    logic [1:0]       issue_valid;
    logic [1:0][7:0]  issue_rd;
    logic [1:0][31:0] issue_rs1_val;
    logic [1:0][31:0] issue_rs2_val;
    logic [1:0][3:0]  issue_op;
    logic [1:0][6:0]  issue_rob_tag;
    logic [3:0]       cdb_valid;
    logic [3:0][7:0]  cdb_tag;
    logic [3:0][31:0] cdb_data;
    logic [3:0][6:0]  cdb_rob_tag;
    logic             busy;

    int total;
    int bad;

    logic [3:0]  v_op [10];
    logic [31:0] v_a  [10];
    logic [31:0] v_b  [10];
    logic [31:0] v_r  [10];

    exec_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stop          (stop),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_rs1_val (issue_rs1_val),
        .issue_rs2_val (issue_rs2_val),
        .issue_op      (issue_op),
        .issue_rob_tag (issue_rob_tag),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .cdb_rob_tag   (cdb_rob_tag),
        .busy          (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled off-edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stop        = 1'b0;
        flush       = 1'b0;
        issue_valid = 2'b00;
    endtask

    task automatic issue(input int k, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [7:0] rd, input logic [6:0] rob);
        issue_valid[k]   = 1'b1;
        issue_op[k]      = op;
        issue_rs1_val[k] = a;
        issue_rs2_val[k] = b;
        issue_rd[k]      = rd;
        issue_rob_tag[k] = rob;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        v_op = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd12, 4'd0};
        v_a  = '{32'h0000_0000, 32'hF0F0_F0F0, 32'h1234_0000, 32'hFFFF_0000, 32'h0000_0001,
                 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF};
        v_b  = '{32'h0000_0001, 32'h0FF0_0FF0, 32'h0000_5678, 32'h0F0F_0F0F, 32'h0000_0024,
                 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0000_0005, 32'h0000_0002};
        v_r  = '{32'hFFFF_FFFF, 32'h00F0_00F0, 32'h1234_5678, 32'hF0F0_0F0F, 32'h0000_0010,
                 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001};

        reset         = 1'b0;
        issue_rd      = '0;
        issue_rs1_val = '0;
        issue_rs2_val = '0;
        issue_op      = '0;
        issue_rob_tag = '0;
        idle();

        // Reset state
        step(); step();
        check("rst_valid", cdb_valid, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_data0", cdb_data[0], 32'h0);
        check("rst_tag3", cdb_tag[3], 8'h00);
        check("rst_rob2", cdb_rob_tag[2], 7'h00);
        reset = 1'b1;
        step();

        // ADD overflow wraps, one cycle latency
        issue(0, 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 8'h12, 7'h05);
        step(); idle(); #1;
        check("add_valid", cdb_valid, 4'b0001);
        check("add_data", cdb_data[0], 32'h8000_0000);
        check("add_tag", cdb_tag[0], 8'h12);
        check("add_rob", cdb_rob_tag[0], 7'h05);
        check("add_busy", busy, 1'b1);
        step(); #1;
        check("add_once", cdb_valid, 4'b0000);
        check("add_idle_busy", busy, 1'b0);

        // MUL on lane1 -> CDB lane 3 after three cycles
        issue(1, 4'd10, 32'h0001_0000, 32'h0001_0001, 8'h20, 7'h11);
        step(); idle(); #1;
        check("mul_c1", cdb_valid, 4'b0000);
        check("mul_c1_busy", busy, 1'b1);
        step(); #1;
        check("mul_c2", cdb_valid, 4'b0000);
        step(); #1;
        check("mul_c3_valid", cdb_valid, 4'b1000);
        check("mul_c3_data", cdb_data[3], 32'h0001_0000);
        check("mul_c3_tag", cdb_tag[3], 8'h20);
        check("mul_c3_rob", cdb_rob_tag[3], 7'h11);
        step(); #1;
        check("mul_c4", cdb_valid, 4'b0000);
        check("mul_c4_busy", busy, 1'b0);

        // ALU op table, two ops per cycle, back to back
        for (int i = 0; i < 5; i++) begin
            issue(0, v_op[2*i], v_a[2*i], v_b[2*i], 8'h50 + 8'(2*i), 7'(2*i));
            issue(1, v_op[2*i+1], v_a[2*i+1], v_b[2*i+1], 8'h50 + 8'(2*i+1), 7'(2*i+1));
            step(); idle(); #1;
            check($sformatf("alu%0d_valid", i), cdb_valid, 4'b0011);
            check($sformatf("alu%0d_l0", i), cdb_data[0], v_r[2*i]);
            check($sformatf("alu%0d_l1", i), cdb_data[1], v_r[2*i+1]);
            check($sformatf("alu%0d_tag1", i), cdb_tag[1], 8'h50 + 8'(2*i+1));
        end
        step(); #1;
        check("alu_tbl_drain", cdb_valid, 4'b0000);

        // MUL lane0 + SRA lane1, then ADD on both lanes two cycles later
        issue(0, 4'd10, 32'h0000_0003, 32'h0000_0005, 8'h30, 7'h30);
        issue(1, 4'd7, 32'h8000_0000, 32'h0000_0004, 8'h31, 7'h31);
        step(); idle(); #1;
        check("mix_c1_valid", cdb_valid, 4'b0010);
        check("mix_c1_sra", cdb_data[1], 32'hF800_0000);
        step();
        issue(0, 4'd0, 32'h0000_0001, 32'h0000_0002, 8'h44, 7'h40);
        issue(1, 4'd0, 32'h0000_000A, 32'h0000_0014, 8'h44, 7'h41);
        #1;
        check("mix_c2_valid", cdb_valid, 4'b0000);
        step(); idle(); #1;
        check("mix_c3_valid", cdb_valid, 4'b0111);
        check("mix_c3_mul", cdb_data[2], 32'h0000_000F);
        check("mix_c3_add0", cdb_data[0], 32'h0000_0003);
        check("mix_c3_add1", cdb_data[1], 32'h0000_001E);
        check("mix_c3_tag0", cdb_tag[0], 8'h44);
        check("mix_c3_tag1", cdb_tag[1], 8'h44);
        step(); #1;
        check("mix_c4_valid", cdb_valid, 4'b0000);

        // Stall: MUL plus an ALU result frozen for five cycles; issues during stop ignored
        issue(0, 4'd10, 32'h0000_0007, 32'h0000_0006, 8'h33, 7'h01);
        issue(1, 4'd3, 32'h0000_000A, 32'h0000_0005, 8'h34, 7'h02);
        step();
        for (int c = 0; c < 5; c++) begin
            idle();
            stop = 1'b1;
            issue(1, 4'd0, 32'h0000_0001, 32'h0000_0001, 8'h77, 7'h77);
            #1;
            check($sformatf("stall%0d_valid", c), cdb_valid, 4'b0000);
            check($sformatf("stall%0d_busy", c), busy, 1'b1);
            step();
        end
        idle(); #1;
        check("unstall0_valid", cdb_valid, 4'b0010);
        check("unstall0_or", cdb_data[1], 32'h0000_000F);
        step(); #1;
        check("unstall1_valid", cdb_valid, 4'b0000);
        step(); #1;
        check("unstall2_valid", cdb_valid, 4'b0100);
        check("unstall2_mul", cdb_data[2], 32'h0000_002A);
        step(); #1;
        check("unstall3_valid", cdb_valid, 4'b0000);
        check("unstall3_busy", busy, 1'b0);

        // Flush (with stop also high) kills two in-flight MULs and same-cycle issue
        issue(0, 4'd10, 32'h0000_0002, 32'h0000_0002, 8'h60, 7'h60);
        step(); idle();
        issue(1, 4'd10, 32'h0000_0003, 32'h0000_0003, 8'h61, 7'h61);
        step(); idle();
        flush = 1'b1;
        stop  = 1'b1;
        issue(0, 4'd0, 32'h0000_0001, 32'h0000_0001, 8'h62, 7'h62);
        step(); idle(); #1;
        check("flush_busy", busy, 1'b0);
        check("flush_valid0", cdb_valid, 4'b0000);
        step(); #1;
        check("flush_valid1", cdb_valid, 4'b0000);
        step(); #1;
        check("flush_valid2", cdb_valid, 4'b0000);

        // Reset during MUL stage 2
        issue(1, 4'd10, 32'h0000_0009, 32'h0000_0009, 8'h70, 7'h70);
        step(); idle();
        step();
        reset = 1'b0;
        #1;
        check("rstmid_valid", cdb_valid, 4'b0000);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_data3", cdb_data[3], 32'h0);
        step();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(); #1;
            check($sformatf("rstrel%0d_valid", c), cdb_valid, 4'b0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
